eth_rx_pkt_writer: RTL
======================

// Module: eth_rx_pkt_writer
// PURPOSE
//  Upstream stage of ecpri_rx. Accepts a received Ethernet byte stream from the MAC FIFO
//  and filters on eCPRI EtherType and frame length. Writes each accepted frame into port 0
//  of the dual-port packet RAM (ram_dp_sr_sw), starting at address 0.
//  Pulses recv_pkt so ecpri_rx can parse the frame through RAM port 1.
// PARAMETERS
//  DATA_WIDTH  8       byte lane width
//  ADDR_WIDTH  16      packet RAM address width
//  MIN_LEN     60      minimum accepted frame length, bytes, FCS excluded
//  MAX_LEN     1500    maximum accepted frame length, bytes; must be < 2**ADDR_WIDTH
//  ETHERTYPE   16'hAEFE  EtherType that is accepted
// PORTS
//  clk       in   1           system clock, all logic on rising edge
//  reset     in   1           asynchronous, active-low reset
//  in_valid  in   1           in_data holds a valid byte
//  in_data   in   DATA_WIDTH  frame byte
//  in_sop    in   1           first byte of frame
//  in_eop    in   1           last byte of frame
//  in_err    in   1           MAC error; sampled with in_eop
//  in_ready  out  1           block can accept a byte
//  ram_addr  out  ADDR_WIDTH  RAM port-0 address
//  ram_wdata out  DATA_WIDTH  write data; top level drives data_0 with it while ram_oe==0
//  ram_cs    out  1           chip select
//  ram_we    out  1           write enable
//  ram_oe    out  1           output enable; held 0 because this block only writes
//  recv_pkt  out  1           one-cycle pulse: frame complete in RAM
//  pkt_len   out  ADDR_WIDTH  byte count of stored frame; valid from recv_pkt until pkt_done
//  pkt_done  in   1           ecpri_rx has finished with the buffer
//  pkt_cnt   out  16          count of accepted frames, wraps
//  drop_cnt  out  16          count of dropped frames, wraps
// BEHAVIOUR
//  Reset values (on reset low):
//   - state=IDLE, in_ready=1, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, ram_wdata=0
//   - recv_pkt=0, pkt_len=0, counters=0
//  Handshake: a byte is accepted when in_valid && in_ready.
//  Write timing: a byte accepted in cycle n is registered to RAM in cycle n+1.
//   - ram_addr = byte index, ram_we=1, ram_cs=1 for exactly that cycle.
//  Completion: when eop is accepted in cycle n, recv_pkt pulses in cycle n+2.
//   - pkt_len = total byte count at the pulse.
//   - in_ready goes 0 from cycle n+1 until the cycle after pkt_done is sampled high.
//  FSM states:
//   - IDLE: waits for an accepted byte with in_sop; writes it to address 0; -> HDR.
//     Bytes accepted without in_sop are discarded silently; no count.
//   - HDR: bytes 1..13. Bytes 12 and 13 are compared with ETHERTYPE[15:8] and [7:0].
//     Match after byte 13 -> BODY. Mismatch -> DROP.
//   - BODY: writes bytes; count+1 per byte.
//     Count would exceed MAX_LEN -> DROP.
//     On eop: if count<MIN_LEN or in_err -> drop, else -> NOTIFY.
//   - DROP: no RAM writes; discards until eop; drop_cnt+1 once; -> IDLE.
//     Already-written RAM bytes are left in place; recv_pkt is not raised.
//   - NOTIFY: recv_pkt=1 for one cycle; pkt_cnt+1; -> WAIT_DONE.
//   - WAIT_DONE: in_ready=0; on pkt_done -> IDLE.
//  Boundary cases:
//   - eop inside HDR (frame <14 bytes): drop.
//   - in_sop during HDR/BODY: the current frame is dropped (drop_cnt+1).
//     The same byte starts a new frame at address 0 in HDR.
//   - in_sop && in_eop on the same byte: single-byte frame; dropped as runt.
//   - pkt_done outside WAIT_DONE: ignored.
//   - reset mid-frame: returns to IDLE immediately; the rest of that frame is discarded
//     until the next in_sop.
//   - Counters wrap from 16'hFFFF to 0.
// STRUCTURE
//  - ecpri_pkg holds the typedef enum for FSM states (IDLE, HDR, BODY, DROP, NOTIFY,
//    WAIT_DONE) and ETHERTYPE_ECPRI = 16'hAEFE.
//  - The block is a single module; no sub-module is needed.
//  - Byte counter width is ADDR_WIDTH+1 so overflow past MAX_LEN is detected.
// TESTING
//  1. 100-byte frame, EtherType AEFE -> 100 writes at addr 0..99 in order; recv_pkt once;
//     pkt_len=100; in_ready=0 until pkt_done; pkt_cnt=1.
//  2. 100-byte frame, EtherType 0800 -> no recv_pkt; drop_cnt=1; writes stop after byte 13;
//     next valid frame is accepted.
//  3. 40-byte AEFE frame, then a 60-byte frame with in_err on eop -> both dropped;
//     drop_cnt=2; no recv_pkt.
//  4. 1501-byte AEFE frame -> drop; no write at addr 1500; drop_cnt=1.
//     1500-byte frame -> accepted with pkt_len=1500.
//  5. in_sop at byte 30 of a frame, then a 64-byte AEFE frame -> drop_cnt=1;
//     pkt_len=64, bytes written from addr 0.
//  6. reset low at byte 50, new 80-byte frame after release -> all outputs at reset values
//     during reset; pkt_len=80 recv_pkt; counters=0 then pkt_cnt=1.

Source files
------------

// File: rtl/ecpri_pkg.sv
// Shared types and constants for the eCPRI receive path.
package ecpri_pkg;

  // Receive-side frame writer states.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    DROP,
    NOTIFY,
    WAIT_DONE
  } rx_state_e;

  // EtherType carried by eCPRI frames.
  localparam logic [15:0] ETHERTYPE_ECPRI = 16'hAEFE;

endpackage

// File: rtl/eth_rx_pkt_writer.sv
// Filters the received Ethernet byte stream on EtherType and length, writes each
// frame into port 0 of the packet RAM from address 0, and hands accepted frames to
// ecpri_rx with a one-cycle recv_pkt pulse. The buffer is held until pkt_done.
module eth_rx_pkt_writer
  import ecpri_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1500,
  parameter logic [15:0] ETHERTYPE  = ETHERTYPE_ECPRI
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_err,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  recv_pkt,
  output logic [ADDR_WIDTH-1:0] pkt_len,
  input  logic                  pkt_done,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           drop_cnt
);

  // One extra bit so a byte index past MAX_LEN is still representable.
  localparam int unsigned CW = ADDR_WIDTH + 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t                  TYPE_HI_IDX = cnt_t'(12);
  localparam cnt_t                  TYPE_LO_IDX = cnt_t'(13);
  localparam cnt_t                  MIN_CNT     = cnt_t'(MIN_LEN);
  localparam cnt_t                  MAX_CNT     = cnt_t'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] TYPE_HI     = DATA_WIDTH'(ETHERTYPE[15:8]);
  localparam logic [DATA_WIDTH-1:0] TYPE_LO     = DATA_WIDTH'(ETHERTYPE[7:0]);

  rx_state_e             state, state_next;
  cnt_t                  cnt, cnt_next, cnt_inc;
  logic                  type_hi_ok, type_hi_next;
  logic                  accept, in_frame, start_frame;
  logic                  wr_en, notify;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [1:0]            drop_inc;

  // Buffer is busy from the accepted eop until ecpri_rx releases it.
  assign in_ready    = (state != NOTIFY) && (state != WAIT_DONE);
  assign ram_oe      = 1'b0;
  assign accept      = in_valid && in_ready;
  assign in_frame    = (state == HDR) || (state == BODY);
  assign start_frame = accept && in_sop;
  assign cnt_inc     = cnt + cnt_t'(1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-cycle write/count decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned and no latch is inferred.
    state_next   = state;
    cnt_next     = cnt;
    type_hi_next = type_hi_ok;
    wr_en        = 1'b0;
    wr_addr      = cnt[ADDR_WIDTH-1:0];
    drop_inc     = 2'd0;
    notify       = 1'b0;

    if (start_frame) begin
      // A start byte always opens a fresh frame at address 0; a frame still in
      // progress is abandoned, and a start byte that is also the end is a runt.
      wr_en        = 1'b1;
      wr_addr      = '0;
      cnt_next     = cnt_t'(1);
      type_hi_next = 1'b0;
      drop_inc     = {1'b0, in_frame} + {1'b0, in_eop};
      state_next   = in_eop ? IDLE : HDR;
    end else begin
      case (state)
        IDLE: ;  // bytes outside a frame are discarded silently

        HDR: if (accept) begin
          wr_en    = 1'b1;
          cnt_next = cnt_inc;
          if (cnt == TYPE_HI_IDX) type_hi_next = (in_data == TYPE_HI);
          if (in_eop) begin
            drop_inc   = 2'd1;
            state_next = IDLE;
          end else if (cnt == TYPE_LO_IDX) begin
            if (type_hi_ok && (in_data == TYPE_LO)) begin
              state_next = BODY;
            end else begin
              drop_inc   = 2'd1;
              state_next = DROP;
            end
          end
        end

        BODY: if (accept) begin
          if (cnt >= MAX_CNT) begin
            // This byte would make the frame longer than MAX_LEN: never written.
            drop_inc   = 2'd1;
            state_next = in_eop ? IDLE : DROP;
          end else begin
            wr_en    = 1'b1;
            cnt_next = cnt_inc;
            if (in_eop) begin
              if ((cnt_inc < MIN_CNT) || in_err) begin
                drop_inc   = 2'd1;
                state_next = IDLE;
              end else begin
                state_next = NOTIFY;
              end
            end
          end
        end

        DROP: if (accept && in_eop) state_next = IDLE;

        NOTIFY: begin
          notify     = 1'b1;
          state_next = WAIT_DONE;
        end

        WAIT_DONE: if (pkt_done) state_next = IDLE;

        default: state_next = IDLE;
      endcase
    end
  end

  // RAM port-0 drive, byte counter, completion pulse and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      recv_pkt   <= 1'b0;
      pkt_len    <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      cnt        <= '0;
      type_hi_ok <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples the
      // pre-edge values, independent of statement order.
      ram_cs     <= wr_en;
      ram_we     <= wr_en;
      recv_pkt   <= notify;
      cnt        <= cnt_next;
      type_hi_ok <= type_hi_next;
      drop_cnt   <= drop_cnt + 16'(drop_inc);
      if (wr_en) begin
        ram_addr  <= wr_addr;
        ram_wdata <= in_data;
      end
      if (notify) begin
        pkt_len <= cnt[ADDR_WIDTH-1:0];
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

endmodule
